// File: rtl/comparator_arbiter_4ch.sv
// Four-requester round-robin arbiter feeding a single registered unsigned comparator.
// One compare every two cycles: grant/capture in IDLE, compare/report in CMP.
module comparator_arbiter_4ch #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       Clock_In,
  input  logic                       Reset_In,
  input  logic                       Enable_In,
  input  logic [NUM_REQ-1:0]         Req_In,
  input  logic [NUM_REQ*WIDTH-1:0]   Data_A_In,
  input  logic [NUM_REQ*WIDTH-1:0]   Data_B_In,
  output logic [NUM_REQ-1:0]         Grant_Out,
  output logic                       Busy_Out,
  output logic                       Valid_Out,
  output logic [1:0]                 Id_Out,
  output logic                       A_gt_B_Out,
  output logic                       A_eq_B_Out,
  output logic                       A_lt_B_Out
);

  localparam int unsigned ID_W = 2;

  typedef enum logic {IDLE = 1'b0, CMP = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 gt_q, gt_d;
  logic                 eq_q, eq_d;
  logic                 lt_q, lt_d;

  logic                 win_found;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W-1:0]      cand;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = last_grant_q + ID_W'(off);
      if (!win_found && Req_In[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    grant_d      = '0;
    valid_d      = 1'b0;
    id_d         = id_q;
    gt_d         = gt_q;
    eq_d         = eq_q;
    lt_d         = lt_q;
    case (state_q)
      IDLE: begin
        if (Enable_In && win_found) begin
          state_d      = CMP;
          last_grant_d = win_idx;
          cur_id_d     = win_idx;
          op_a_d       = Data_A_In[32'(win_idx)*WIDTH +: WIDTH];
          op_b_d       = Data_B_In[32'(win_idx)*WIDTH +: WIDTH];
          grant_d      = NUM_REQ'(1) << win_idx;
        end
      end
      CMP: begin
        state_d = IDLE;
        valid_d = 1'b1;
        id_d    = cur_id_q;
        gt_d    = (op_a_q > op_b_q);
        eq_d    = (op_a_q == op_b_q);
        lt_d    = (op_a_q < op_b_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset makes requester 0 highest priority.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cur_id_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      grant_q      <= '0;
      valid_q      <= 1'b0;
      id_q         <= '0;
      gt_q         <= 1'b0;
      eq_q         <= 1'b0;
      lt_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      grant_q      <= grant_d;
      valid_q      <= valid_d;
      id_q         <= id_d;
      gt_q         <= gt_d;
      eq_q         <= eq_d;
      lt_q         <= lt_d;
    end
  end

  assign Grant_Out  = grant_q;
  assign Busy_Out   = (state_q == CMP);
  assign Valid_Out  = valid_q;
  assign Id_Out     = id_q;
  assign A_gt_B_Out = gt_q;
  assign A_eq_B_Out = eq_q;
  assign A_lt_B_Out = lt_q;

endmodule

// File: tb/tb_comparator_arbiter_4ch.sv
// Directed bench for comparator_arbiter_4ch with hand-computed expectations.
module tb_comparator_arbiter_4ch;

  localparam int unsigned WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] a_bus;
  logic [4*WIDTH-1:0] b_bus;
  logic [3:0]         grant;
  logic               busy;
  logic               valid;
  logic [1:0]         id;
  logic               gt, eq, lt;

  int compared = 0;
  int failed   = 0;

  comparator_arbiter_4ch #(.WIDTH(WIDTH), .NUM_REQ(4)) dut (
    .Clock_In  (clk),
    .Reset_In  (rst),
    .Enable_In (en),
    .Req_In    (req),
    .Data_A_In (a_bus),
    .Data_B_In (b_bus),
    .Grant_Out (grant),
    .Busy_Out  (busy),
    .Valid_Out (valid),
    .Id_Out    (id),
    .A_gt_B_Out(gt),
    .A_eq_B_Out(eq),
    .A_lt_B_Out(lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_op(input int unsigned i, input logic [31:0] a, input logic [31:0] b);
    a_bus[i*WIDTH +: WIDTH] = a;
    b_bus[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic chk_result(input string tag, input logic [1:0] eid,
                            input logic egt, input logic eeq, input logic elt);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_grant0"}, 32'(grant), 32'd0);
    chk({tag, "_id"}, 32'(id), 32'(eid));
    chk({tag, "_flags"}, {29'd0, gt, eq, lt}, {29'd0, egt, eeq, elt});
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    req   = 4'b0000;
    a_bus = '0;
    b_bus = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_outputs", {22'd0, grant, busy, valid, id, gt, eq, lt}, 32'd0);

    // Single request: 5 vs 3 -> gt
    set_op(0, 32'd5, 32'd3);
    req = 4'b0001;
    en  = 1'b1;
    tick();
    chk("single_grant", 32'(grant), 32'b0001);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_novalid", 32'(valid), 32'd0);
    req = 4'b0000;
    tick();
    chk_result("single", 2'd0, 1'b1, 1'b0, 1'b0);
    chk("single_busy_clr", 32'(busy), 32'd0);
    tick();
    chk("hold_valid_drop", 32'(valid), 32'd0);
    chk("hold_flags", {29'd0, gt, eq, lt}, 32'b100);

    // Contention: all four request continuously
    do_reset();
    set_op(0, 32'd1, 32'd2);
    set_op(1, 32'd2, 32'd2);
    set_op(2, 32'd3, 32'd2);
    set_op(3, 32'd0, 32'd9);
    en  = 1'b1;
    req = 4'b1111;
    tick(); chk("rr_g0", 32'(grant), 32'b0001);
    tick(); chk_result("rr_r0", 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); chk("rr_g1", 32'(grant), 32'b0010);
    tick(); chk_result("rr_r1", 2'd1, 1'b0, 1'b1, 1'b0);
    tick(); chk("rr_g2", 32'(grant), 32'b0100);
    tick(); chk_result("rr_r2", 2'd2, 1'b1, 1'b0, 1'b0);
    tick(); chk("rr_g3", 32'(grant), 32'b1000);
    tick(); chk_result("rr_r3", 2'd3, 1'b0, 1'b0, 1'b1);
    tick(); chk("rr_g0_again", 32'(grant), 32'b0001);

    // Extremes, plus operand change after capture
    do_reset();
    en = 1'b1;
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0000);
    req = 4'b0001;
    tick();
    chk("ext_gt_grant", 32'(grant), 32'b0001);
    req = 4'b0000;
    set_op(0, 32'h0000_0000, 32'hFFFF_FFFF);
    tick();
    chk_result("ext_gt", 2'd0, 1'b1, 1'b0, 1'b0);
    req = 4'b0001;
    tick();
    chk("ext_lt_grant", 32'(grant), 32'b0001);
    req = 4'b0000;
    tick();
    chk_result("ext_lt", 2'd0, 1'b0, 1'b0, 1'b1);
    set_op(0, 32'h8000_0000, 32'h8000_0000);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    chk_result("ext_eq", 2'd0, 1'b0, 1'b1, 1'b0);

    // Enable gating, then Enable falling during CMP
    do_reset();
    set_op(2, 32'd7, 32'd9);
    en  = 1'b0;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gate_nogrant", {30'd0, busy, |grant}, 32'd0);
    end
    en = 1'b1;
    tick();
    chk("gate_grant", 32'(grant), 32'b0100);
    en = 1'b0;
    tick();
    chk_result("gate_result", 2'd2, 1'b0, 1'b0, 1'b1);

    // Reset mid-CMP discards result
    en = 1'b1;
    tick();
    chk("midrst_grant", 32'(grant), 32'b0100);
    rst = 1'b1;
    req = 4'b0000;
    tick();
    chk("midrst_outputs", {22'd0, grant, busy, valid, id, gt, eq, lt}, 32'd0);
    rst = 1'b0;
    set_op(0, 32'd4, 32'd4);
    set_op(3, 32'd10, 32'd1);
    req = 4'b1001;
    tick();
    chk("midrst_grant0", 32'(grant), 32'b0001);
    chk("midrst_novalid", 32'(valid), 32'd0);
    tick();
    chk_result("midrst_r0", 2'd0, 1'b0, 1'b1, 1'b0);

    // Wrap: 0 -> 3 -> 0 with 1001 held
    tick();
    chk("wrap_grant3", 32'(grant), 32'b1000);
    tick();
    chk_result("wrap_r3", 2'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("wrap_grant0", 32'(grant), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
